// File: rtl/amp_seq_ctrl.sv
// Multi-amplifier power/mute sequencer with frame-aligned I2S gating.
// Optional auto-retry out of FAULT is enabled by defining AMP_SEQ_RETRY_EN.
module amp_seq_ctrl #(
    parameter int unsigned N_AMP       = 2,
    parameter int unsigned LOCK_WAIT   = 1024,
    parameter int unsigned EN_SETTLE   = 256,
    parameter int unsigned CFG_TIMEOUT = 4096,
    parameter int unsigned MUTE_HOLD   = 256,
    parameter int unsigned RETRY_WAIT  = 65536
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic             audio_locked,
    input  logic [N_AMP-1:0] nerror_in,
    input  logic             cfg_done,
    input  logic             cfg_err,
    input  logic             i2s_bck_in,
    input  logic             i2s_ws_in,
    input  logic [N_AMP-1:0] i2s_d_in,
    output logic             send_cfg,
    output logic [N_AMP-1:0] amp_nenable,
    output logic [N_AMP-1:0] amp_nmute,
    output logic             i2s_bck_out,
    output logic             i2s_ws_out,
    output logic [N_AMP-1:0] i2s_d_out,
    output logic [N_AMP-1:0] fault_out,
    output logic [2:0]       state_out
);

    localparam int unsigned MAX_A = (LOCK_WAIT > EN_SETTLE) ? LOCK_WAIT : EN_SETTLE;
    localparam int unsigned MAX_B = (CFG_TIMEOUT > MUTE_HOLD) ? CFG_TIMEOUT : MUTE_HOLD;
    localparam int unsigned MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned MAX_T = (MAX_C > RETRY_WAIT) ? MAX_C : RETRY_WAIT;
    localparam int unsigned CNT_W = $clog2(MAX_T) + 1;

    typedef enum logic [2:0] {
        S_OFF         = 3'd0,
        S_WAIT_LOCK   = 3'd1,
        S_ENABLE      = 3'd2,
        S_CONFIG      = 3'd3,
        S_UNMUTE_WAIT = 3'd4,
        S_RUN         = 3'd5,
        S_MUTE_WAIT   = 3'd6,
        S_FAULT       = 3'd7
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               cnt_clr;
    logic [N_AMP-1:0]   fault_nxt;
    logic               ws_prev;
    logic               abort;
    logic               ws_rise;
    logic               amp_on_nxt;
    logic               run_nxt;
    logic               send_nxt;

    // Next-state, shared counter and registered-output targets
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        fault_nxt = fault_out;
        abort     = !ena || !audio_locked;
        ws_rise   = i2s_ws_in && !ws_prev;

        case (state)
            S_OFF: begin
                if (ena && audio_locked) state_nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (!ena)                               state_nxt = S_OFF;
                else if (!audio_locked)                 cnt_clr   = 1'b1;
                else if (cnt == CNT_W'(LOCK_WAIT - 1))  state_nxt = S_ENABLE;
            end
            S_ENABLE: begin
                if (abort)                              state_nxt = S_MUTE_WAIT;
                else if (cnt == CNT_W'(EN_SETTLE - 1))  state_nxt = S_CONFIG;
            end
            S_CONFIG: begin
                // cfg_err outranks a simultaneous cfg_done
                if (cfg_err || cnt == CNT_W'(CFG_TIMEOUT - 1)) begin
                    state_nxt = S_FAULT;
                    fault_nxt = '1;
                end else if (abort) begin
                    state_nxt = S_MUTE_WAIT;
                end else if (cfg_done) begin
                    state_nxt = S_UNMUTE_WAIT;
                end
            end
            S_UNMUTE_WAIT: begin
                if (abort)        state_nxt = S_MUTE_WAIT;
                else if (ws_rise) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (abort || !(&nerror_in)) begin
                    state_nxt = S_MUTE_WAIT;
                    fault_nxt = fault_out | ~nerror_in;
                end
            end
            S_MUTE_WAIT: begin
                if (cnt == CNT_W'(MUTE_HOLD - 1))
                    state_nxt = (|fault_out) ? S_FAULT : S_OFF;
            end
            S_FAULT: begin
                if (!ena) begin
                    state_nxt = S_OFF;
                    fault_nxt = '0;
                end
`ifdef AMP_SEQ_RETRY_EN
                else if (cnt == CNT_W'(RETRY_WAIT - 1)) begin
                    state_nxt = S_OFF;
                end
`endif
            end
            default: state_nxt = S_OFF;
        endcase

        cnt_nxt    = (state_nxt != state || cnt_clr) ? '0 : cnt + CNT_W'(1);
        amp_on_nxt = (state_nxt == S_ENABLE) || (state_nxt == S_CONFIG) ||
                     (state_nxt == S_UNMUTE_WAIT) || (state_nxt == S_RUN) ||
                     (state_nxt == S_MUTE_WAIT);
        run_nxt    = (state_nxt == S_RUN);
        send_nxt   = (state_nxt == S_CONFIG) && (state != S_CONFIG);
    end

    // Outputs track the next state so they change on the same edge as state_out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_OFF;
            cnt         <= '0;
            ws_prev     <= 1'b0;
            send_cfg    <= 1'b0;
            amp_nenable <= '1;
            amp_nmute   <= '0;
            i2s_bck_out <= 1'b0;
            i2s_ws_out  <= 1'b0;
            i2s_d_out   <= '0;
            fault_out   <= '0;
            state_out   <= 3'd0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            ws_prev     <= i2s_ws_in;
            send_cfg    <= send_nxt;
            amp_nenable <= {N_AMP{!amp_on_nxt}};
            amp_nmute   <= {N_AMP{run_nxt}};
            i2s_bck_out <= i2s_bck_in & run_nxt;
            i2s_ws_out  <= i2s_ws_in & run_nxt;
            i2s_d_out   <= i2s_d_in & {N_AMP{run_nxt}};
            fault_out   <= fault_nxt;
            state_out   <= state_nxt;
        end
    end

endmodule
